// File: rtl/idct_fsm.sv
// Sequencer for the inverse 2-D transform: column IDCT, transpose load/unload, row IDCT, output burst.
// Latency: start sampled at edge 0 -> done high 2*IDCT_DELAY + 2*TRANS_DELAY + OUT_BEATS + 1 cycles later (+ stalls).
// Backpressure: out_valid holds through out_ready-low cycles; the beat counter advances only on handshakes.
//
// Ports:
//   clk, rst (async, active-high) | start, out_ready (in)
//   load_1idct, load_trans, unload_trans, load_2idct, out_valid, busy, done (out, registered)
// Build option: define IDCT_START_QUEUE_EN to latch one start request seen while busy
// and chain it back-to-back from DONE into ONE_IDCT.
module idct_fsm #(
  parameter int IDCT_DELAY  = 8,
  parameter int TRANS_DELAY = 32,
  parameter int OUT_BEATS   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic out_ready,
  output logic load_1idct,
  output logic load_trans,
  output logic unload_trans,
  output logic load_2idct,
  output logic out_valid,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ONE_IDCT     = 3'd1,
    S_LOAD_TRANS   = 3'd2,
    S_UNLOAD_TRANS = 3'd3,
    S_TWO_IDCT     = 3'd4,
    S_OUTPUT       = 3'd5,
    S_DONE         = 3'd6
  } state_t;

  localparam logic [6:0] IDCT_LAST  = 7'(IDCT_DELAY - 1);
  localparam logic [6:0] TRANS_LAST = 7'(TRANS_DELAY - 1);
  localparam logic [6:0] OUT_LAST   = 7'(OUT_BEATS - 1);

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;

  logic load_1idct_q, load_trans_q, unload_trans_q, load_2idct_q;
  logic out_valid_q, busy_q, done_q;

`ifdef IDCT_START_QUEUE_EN
  logic pend_q, pend_d;
`endif

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE:         if (start) state_d = S_ONE_IDCT;
      S_ONE_IDCT:     if (cnt_q == IDCT_LAST) state_d = S_LOAD_TRANS;
      S_LOAD_TRANS:   if (cnt_q == TRANS_LAST) state_d = S_UNLOAD_TRANS;
      S_UNLOAD_TRANS: if (cnt_q == TRANS_LAST) state_d = S_TWO_IDCT;
      S_TWO_IDCT:     if (cnt_q == IDCT_LAST) state_d = S_OUTPUT;
      S_OUTPUT:       if (out_ready && (cnt_q == OUT_LAST)) state_d = S_DONE;
      S_DONE: begin
`ifdef IDCT_START_QUEUE_EN
        if (pend_q || start) state_d = S_ONE_IDCT;
        else                 state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default:        state_d = S_IDLE;  // illegal encoding recovers
    endcase

    if (state_d != state_q) begin
      cnt_d = 7'd0;
    end else begin
      case (state_q)
        S_ONE_IDCT, S_LOAD_TRANS, S_UNLOAD_TRANS, S_TWO_IDCT: cnt_d = cnt_q + 7'd1;
        // out_valid is high throughout OUTPUT, so out_ready alone marks a handshake
        S_OUTPUT: if (out_ready) cnt_d = cnt_q + 7'd1;
        default:  cnt_d = cnt_q;
      endcase
    end
  end

`ifdef IDCT_START_QUEUE_EN
  // One-deep start queue; a request taken directly from DONE consumes the slot
  always_comb begin
    pend_d = pend_q;
    if ((state_q == S_DONE) && (state_d == S_ONE_IDCT)) pend_d = 1'b0;
    else if (busy_q && start)                           pend_d = 1'b1;
  end
`endif

  // State, counter and registered Moore outputs (decoded from next state so
  // each output flop matches the state it belongs to)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 7'd0;
      load_1idct_q   <= 1'b0;
      load_trans_q   <= 1'b0;
      unload_trans_q <= 1'b0;
      load_2idct_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef IDCT_START_QUEUE_EN
      pend_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      load_1idct_q   <= (state_d == S_ONE_IDCT) || (state_d == S_LOAD_TRANS);
      load_trans_q   <= (state_d == S_LOAD_TRANS);
      unload_trans_q <= (state_d == S_UNLOAD_TRANS);
      load_2idct_q   <= (state_d == S_UNLOAD_TRANS) || (state_d == S_TWO_IDCT);
      out_valid_q    <= (state_d == S_OUTPUT);
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
`ifdef IDCT_START_QUEUE_EN
      pend_q         <= pend_d;
`endif
    end
  end

  assign load_1idct   = load_1idct_q;
  assign load_trans   = load_trans_q;
  assign unload_trans = unload_trans_q;
  assign load_2idct   = load_2idct_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_idct_fsm.sv
module tb_idct_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_m, out_ready;

  logic l1, lt, ut, l2, ov, bz, dn;
  logic l1_m, lt_m, ut_m, l2_m, ov_m, bz_m, dn_m;

  wire [6:0] o   = {l1, lt, ut, l2, ov, bz, dn};
  wire [6:0] o_m = {l1_m, lt_m, ut_m, l2_m, ov_m, bz_m, dn_m};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  idct_fsm dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .load_1idct(l1), .load_trans(lt), .unload_trans(ut), .load_2idct(l2),
    .out_valid(ov), .busy(bz), .done(dn)
  );

  idct_fsm #(.IDCT_DELAY(1), .TRANS_DELAY(1), .OUT_BEATS(1)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .out_ready(out_ready),
    .load_1idct(l1_m), .load_trans(lt_m), .unload_trans(ut_m), .load_2idct(l2_m),
    .out_valid(ov_m), .busy(bz_m), .done(dn_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Vector order {load_1idct, load_trans, unload_trans, load_2idct, out_valid, busy, done}
  // for default parameters; stall extends OUTPUT and delays DONE.
  function automatic logic [6:0] exp_vec(input int c, input int stall);
    if (c >= 1  && c <= 8)          return 7'b1000010;
    if (c >= 9  && c <= 40)         return 7'b1100010;
    if (c >= 41 && c <= 72)         return 7'b0011010;
    if (c >= 73 && c <= 80)         return 7'b0001010;
    if (c >= 81 && c <= 88 + stall) return 7'b0000110;
    if (c == 89 + stall)            return 7'b0000011;
    return 7'b0000000;
  endfunction

  function automatic logic [6:0] exp_min(input int c);
    case (c)
      1:       return 7'b1000010;
      2:       return 7'b1100010;
      3:       return 7'b0011010;
      4:       return 7'b0001010;
      5:       return 7'b0000110;
      6:       return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Start a block at edge 0 and check every cycle up to ncyc.
  // stall_n: out_ready low for that many cycles starting at cycle 84.
  // extra_start: cycle whose ending edge sees a second start pulse (-1 = none).
  task automatic run_block(input string tag, input int ncyc, input int stall_n,
                           input int extra_start, input bit queued);
    logic [6:0] e;
    bit stalling;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    forever begin
      if (queued && cyc > 89) e = exp_vec(cyc - 89, 0);
      else                    e = exp_vec(cyc, stall_n);
      chk(tag, {25'd0, o}, {25'd0, e});
      stalling  = (stall_n > 0) && (cyc >= 84) && (cyc < 84 + stall_n);
      if (stalling) chk("cnt_frozen", {25'd0, dut.cnt_q}, 32'd3);
      out_ready = !stalling;
      start     = (cyc == extra_start);
      if (cyc >= ncyc) break;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_m = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #11;
    chk("reset_outs", {25'd0, o}, 32'd0);
    chk("reset_outs_min", {25'd0, o_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {25'd0, o}, 32'd0);

    // Nominal block, no stall
    run_block("nominal", 95, 0, -1, 1'b0);

    // Output stall for five cycles: done moves to cycle 94
    run_block("stall", 100, 5, -1, 1'b0);

    // Start during LOAD_TRANS
`ifdef IDCT_START_QUEUE_EN
    run_block("queued", 185, 0, 30, 1'b1);
`else
    run_block("start_busy", 100, 0, 30, 1'b0);
`endif

    // Asynchronous reset in UNLOAD_TRANS
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    while (cyc < 50) tick();
    chk("pre_rst_unload", {25'd0, o}, 32'b0011010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {25'd0, o}, 32'd0);
    chk("async_rst_cnt", {25'd0, dut.cnt_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {25'd0, o}, 32'd0);
    run_block("after_rst", 92, 0, -1, 1'b0);

    // Minimum parameters: one cycle per phase
    start_m = 1'b1;
    cyc = 0;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("min_params", {25'd0, o_m}, {25'd0, exp_min(cyc)});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
